// File: rtl/systolic_seq_if.sv
// Host-side port bundle for systolic_seq: operand loads, job control and the
// result stream. The optional accum input exists only with SYSTOLIC_ACCUM_EN.
interface systolic_seq_if #(
    parameter int N  = 2,
    parameter int DW = 16,
    parameter int IW = $clog2(N*N)
);
    logic          ld_valid;
    logic          ld_sel;
    logic [IW-1:0] ld_idx;
    logic [DW-1:0] ld_data;
    logic          start;
`ifdef SYSTOLIC_ACCUM_EN
    logic          accum;
`endif
    logic          busy;
    logic          done;
    logic          res_valid;
    logic          res_ready;
    logic [IW-1:0] res_idx;
    logic [31:0]   res_data;

`ifdef SYSTOLIC_ACCUM_EN
    modport master (output ld_valid, ld_sel, ld_idx, ld_data, start, accum, res_ready,
                    input  busy, done, res_valid, res_idx, res_data);
    modport slave  (input  ld_valid, ld_sel, ld_idx, ld_data, start, accum, res_ready,
                    output busy, done, res_valid, res_idx, res_data);
`else
    modport master (output ld_valid, ld_sel, ld_idx, ld_data, start, res_ready,
                    input  busy, done, res_valid, res_idx, res_data);
    modport slave  (input  ld_valid, ld_sel, ld_idx, ld_data, start, res_ready,
                    output busy, done, res_valid, res_idx, res_data);
`endif
endinterface

// File: rtl/systolic_seq.sv
// Sequencer for an N x N systolic MAC array: buffers A/B, clears the PEs,
// feeds skewed operands on the west/north edges, waits for the wavefront to
// drain, then streams the N*N accumulators out over valid/ready.
// Optional feature macro SYSTOLIC_ACCUM_EN: adds host.accum, which skips the
// clear so a job adds onto the previous accumulators.
module systolic_seq #(
    parameter int N  = 2,
    parameter int DW = 16,
    parameter int IW = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              rst_n,
    systolic_seq_if.slave     host,
    output logic              arr_clr,
    output logic [N*DW-1:0]   west_bus,
    output logic [N*DW-1:0]   north_bus,
    input  logic [N*N*32-1:0] arr_out
);
    localparam int NN = N*N;
    localparam int TW = $clog2(3*N);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;

    state_t        state, state_n;
    logic [TW-1:0] t, t_n;
    logic [IW-1:0] r, r_n;
    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];

    logic            hs, last, idx_ok, accum_go;
    logic            clr_d, busy_d, done_d, valid_d;
    logic [IW-1:0]   idx_d;
    logic [31:0]     data_d;
    logic [N*DW-1:0] west_d, north_d;
    int              k;

    assign hs   = host.res_valid & host.res_ready;
    assign last = (r == IW'(NN-1));

`ifdef SYSTOLIC_ACCUM_EN
    assign accum_go = host.accum;
`else
    assign accum_go = 1'b0;
`endif

    // Out-of-range load indices only exist when N*N is not a power of two.
    generate
        if (NN == (1 << IW)) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_chk
            assign idx_ok = (host.ld_idx < IW'(NN));
        end
    endgenerate

    // Operand buffers: writable only while idle so a running job sees stable data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NN; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
            end
        end else if (state == IDLE && host.ld_valid && idx_ok) begin
            if (host.ld_sel) b_mem[host.ld_idx] <= host.ld_data;
            else             a_mem[host.ld_idx] <= host.ld_data;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t     <= '0;
            r     <= '0;
        end else begin
            state <= state_n;
            t     <= t_n;
            r     <= r_n;
        end
    end

    // Next state: t walks feed then drain, r walks the result index.
    always_comb begin
        state_n = state;
        t_n     = t;
        r_n     = r;
        case (state)
            IDLE: begin
                if (host.start) begin
                    t_n     = '0;
                    state_n = accum_go ? FEED : CLEAR;
                end
            end
            CLEAR: begin
                t_n     = '0;
                state_n = FEED;
            end
            FEED: begin
                t_n = t + 1'b1;
                if (t == TW'(2*N-2)) state_n = DRAIN;
            end
            DRAIN: begin
                if (t == TW'(3*N-2)) begin
                    t_n     = '0;
                    r_n     = '0;
                    state_n = OUT;
                end else begin
                    t_n = t + 1'b1;
                end
            end
            OUT: begin
                if (hs) begin
                    if (last) begin
                        r_n     = '0;
                        state_n = IDLE;
                    end else begin
                        r_n = r + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so every
    // output can be a plain register.
    always_comb begin
        clr_d   = (state_n == CLEAR);
        busy_d  = (state_n != IDLE);
        done_d  = (state == OUT) && hs && last;
        valid_d = (state_n == OUT);
        idx_d   = '0;
        data_d  = '0;
        west_d  = '0;
        north_d = '0;
        k       = 0;
        if (state_n == FEED) begin
            // Row i / column j lag by i / j cycles to form the diagonal wavefront.
            for (int i = 0; i < N; i++) begin
                k = int'(t_n) - i;
                if (k >= 0 && k < N) begin
                    west_d[i*DW +: DW]  = a_mem[IW'(i*N + k)];
                    north_d[i*DW +: DW] = b_mem[IW'(k*N + i)];
                end
            end
        end
        if (state_n == OUT) begin
            idx_d = r_n;
            // Hold the presented word under backpressure.
            data_d = (state == OUT && !hs) ? host.res_data : arr_out[int'(r_n)*32 +: 32];
        end
    end

    // Output registers; the array is held in clear while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_clr        <= 1'b1;
            host.busy      <= 1'b0;
            host.done      <= 1'b0;
            host.res_valid <= 1'b0;
            host.res_idx   <= '0;
            host.res_data  <= '0;
            west_bus       <= '0;
            north_bus      <= '0;
        end else begin
            arr_clr        <= clr_d;
            host.busy      <= busy_d;
            host.done      <= done_d;
            host.res_valid <= valid_d;
            host.res_idx   <= idx_d;
            host.res_data  <= data_d;
            west_bus       <= west_d;
            north_bus      <= north_d;
        end
    end
endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: a small MAC-grid model stands in for the array,
// expected results come from plain matrix multiplication and are checked by
// an independent result monitor.
module tb_systolic_seq;
    localparam int N  = 2;
    localparam int DW = 16;
    localparam int NN = N*N;
    localparam int IW = $clog2(NN);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arr_clr;
    logic [N*DW-1:0]   west_bus, north_bus;
    logic [N*N*32-1:0] arr_out;

    systolic_seq_if #(.N(N), .DW(DW), .IW(IW)) hif ();

    systolic_seq #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .host(hif), .arr_clr(arr_clr),
        .west_bus(west_bus), .north_bus(north_bus), .arr_out(arr_out)
    );

    always #5 clk = ~clk;

    // ---------------- array model: PE grid, operands flow east / south
    logic [DW-1:0] pa [N][N], pb [N][N], win [N][N], nin [N][N];
    logic [31:0]   pacc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                win[i][j] = (j == 0) ? west_bus[i*DW +: DW]  : pa[i][(j == 0) ? 0 : j-1];
                nin[i][j] = (i == 0) ? north_bus[j*DW +: DW] : pb[(i == 0) ? 0 : i-1][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_clr) begin
                    pa[i][j]   <= '0;
                    pb[i][j]   <= '0;
                    pacc[i][j] <= '0;
                end else begin
                    pa[i][j]   <= win[i][j];
                    pb[i][j]   <= nin[i][j];
                    pacc[i][j] <= pacc[i][j] + 32'(win[i][j]) * 32'(nin[i][j]);
                end
            end
        end
    end

    always_comb begin
        arr_out = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_out[(i*N+j)*32 +: 32] = pacc[i][j];
    end

    // ---------------- reference model and scoreboard
    logic [DW-1:0] ra [NN], rb [NN];
    logic [31:0]   rc [NN];
    int            q_idx [$];
    logic [31:0]   q_dat [$];
    logic [31:0]   first_exp;
    int            n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // C = A*B (or C += A*B when accumulating), pushed in row-major order.
    task automatic push_expected(input bit acc);
        logic [31:0] s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = acc ? rc[i*N+j] : 32'd0;
                for (int kk = 0; kk < N; kk++)
                    s = s + 32'(ra[i*N+kk]) * 32'(rb[kk*N+j]);
                rc[i*N+j] = s;
                q_idx.push_back(i*N+j);
                q_dat.push_back(s);
                if (i == 0 && j == 0) first_exp = s;
            end
        end
    endtask

    // Monitor: every handshake consumes one expected result.
    initial begin
        int ei;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (rst_n && hif.res_valid && hif.res_ready) begin
                if (q_dat.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_result: idx %0d data %0d with nothing expected",
                             hif.res_idx, hif.res_data);
                end else begin
                    ei = q_idx.pop_front();
                    ed = q_dat.pop_front();
                    chk("res_idx", 64'(hif.res_idx), 64'(ei));
                    chk("res_data", 64'(hif.res_data), 64'(ed));
                end
            end
        end
    end

    // ---------------- stimulus (tasks start and end 1 time unit after a rising edge)
    task automatic ld(input bit sel, input int idx, input logic [DW-1:0] d);
        hif.ld_valid = 1'b1;
        hif.ld_sel   = sel;
        hif.ld_idx   = IW'(idx);
        hif.ld_data  = d;
        @(posedge clk); #1;
        hif.ld_valid = 1'b0;
        if (sel) rb[idx] = d; else ra[idx] = d;
    endtask

    task automatic load_mats(input logic [DW-1:0] a [NN], input logic [DW-1:0] b [NN]);
        for (int e = 0; e < NN; e++) ld(1'b0, e, a[e]);
        for (int e = 0; e < NN; e++) ld(1'b1, e, b[e]);
    endtask

    // mode 0: ready held high, 1: random ready, 2: 5-cycle stall on the first result
    task automatic run_job(input bit acc, input int mode, input bit feed_chk, input bit lock);
        int c, first_v, done_c;
        bit saw_clr;
        push_expected(acc);
        hif.start     = 1'b1;
`ifdef SYSTOLIC_ACCUM_EN
        hif.accum     = acc;
`endif
        hif.res_ready = 1'b1;
        @(posedge clk); #1;
        first_v = 0; done_c = 0; saw_clr = 1'b0;
        for (c = 1; c < 200 && done_c == 0; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            hif.start    = 1'b0;
            hif.ld_valid = 1'b0;
            if (arr_clr) saw_clr = 1'b1;
            if (c == 1) chk("busy_after_start", 64'(hif.busy), 64'd1);
            if (lock && c == 3) begin
                hif.start    = 1'b1;
                hif.ld_valid = 1'b1;
                hif.ld_sel   = 1'b0;
                hif.ld_idx   = '0;
                hif.ld_data  = 16'd9;
            end
            if (feed_chk && c == (acc ? 2 : 3)) begin
                chk("west_bus_t1", 64'(west_bus), 64'({16'd3, 16'd2}));
                chk("north_bus_t1", 64'(north_bus), 64'({16'd6, 16'd7}));
            end
            if (hif.res_valid && first_v == 0) first_v = c;
            case (mode)
                1: hif.res_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (first_v != 0 && c < first_v + 5) begin
                        hif.res_ready = 1'b0;
                        chk("stall_idx", 64'(hif.res_idx), 64'd0);
                        chk("stall_data", 64'(hif.res_data), 64'(first_exp));
                    end else begin
                        hif.res_ready = 1'b1;
                    end
                end
                default: hif.res_ready = 1'b1;
            endcase
            if (hif.done) done_c = c;
        end
        chk("job_finished", 64'(done_c != 0), 64'd1);
        chk("first_valid_cycle", 64'(first_v), acc ? 64'(3*N) : 64'(3*N+1));
        chk("arr_clr_pulse", 64'(saw_clr), 64'(!acc));
        if (mode == 0) chk("done_cycle", 64'(done_c), 64'(first_v + NN));
        chk("busy_at_done", 64'(hif.busy), 64'd0);
        hif.res_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_single_pulse", 64'(hif.done), 64'd0);
        chk("idle_after_job", 64'(hif.busy), 64'd0);
        chk("all_results_seen", 64'(q_dat.size()), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] ma [NN], mb [NN];
        bit acc_r;
        rst_n         = 1'b0;
        hif.ld_valid  = 1'b0;
        hif.ld_sel    = 1'b0;
        hif.ld_idx    = '0;
        hif.ld_data   = '0;
        hif.start     = 1'b0;
        hif.res_ready = 1'b0;
`ifdef SYSTOLIC_ACCUM_EN
        hif.accum     = 1'b0;
`endif
        for (int e = 0; e < NN; e++) begin ra[e] = '0; rb[e] = '0; rc[e] = '0; end

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arr_clr", 64'(arr_clr), 64'd1);
        chk("rst_busy", 64'(hif.busy), 64'd0);
        chk("rst_done", 64'(hif.done), 64'd0);
        chk("rst_res_valid", 64'(hif.res_valid), 64'd0);
        chk("rst_res_idx", 64'(hif.res_idx), 64'd0);
        chk("rst_res_data", 64'(hif.res_data), 64'd0);
        chk("rst_west", 64'(west_bus), 64'd0);
        chk("rst_north", 64'(north_bus), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arr_clr_release", 64'(arr_clr), 64'd0);

        // basic job, then stalled output, then lockout and a repeat run
        ma = '{16'd1, 16'd2, 16'd3, 16'd4};
        mb = '{16'd5, 16'd6, 16'd7, 16'd8};
        load_mats(ma, mb);
        run_job(1'b0, 0, 1'b1, 1'b0);
        run_job(1'b0, 2, 1'b0, 1'b0);
        run_job(1'b0, 0, 1'b0, 1'b1);
        run_job(1'b0, 0, 1'b0, 1'b0);
`ifdef SYSTOLIC_ACCUM_EN
        run_job(1'b1, 0, 1'b1, 1'b0);
`endif

        // reset in the middle of feeding (t = 1)
        hif.start = 1'b1;
        @(posedge clk); #1;
        hif.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(hif.busy), 64'd0);
        chk("midrst_arr_clr", 64'(arr_clr), 64'd1);
        chk("midrst_west", 64'(west_bus), 64'd0);
        chk("midrst_valid", 64'(hif.res_valid), 64'd0);
        q_idx.delete();
        q_dat.delete();
        for (int e = 0; e < NN; e++) begin ra[e] = '0; rb[e] = '0; rc[e] = '0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(1'b0, 0, 1'b0, 1'b0);   // buffers were cleared: all-zero results
        load_mats(ma, mb);
        run_job(1'b0, 0, 1'b1, 1'b0);

        // randomized operands and consumer
        for (int it = 0; it < 6; it++) begin
            for (int e = 0; e < NN; e++) begin
                ma[e] = DW'($urandom);
                mb[e] = DW'($urandom);
            end
            load_mats(ma, mb);
            acc_r = 1'b0;
`ifdef SYSTOLIC_ACCUM_EN
            acc_r = 1'($urandom_range(0, 1));
`endif
            run_job(acc_r, 1, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
